regfile_writer: RTL and testbench

REGFILE_WRITER -- requirements
Module: regfile_writer

---
 rtl/regfile_writer.sv | 88 ++++++++
 tb/tb_regfile_writer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writer.sv
// regfile_writer: 32x8 register file loaded by single writes or by a streamed burst
module regfile_writer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         we,
    input  logic [4:0]   wsel,
    input  logic [7:0]   wdata,
    input  logic         burst_start,
    input  logic [4:0]   burst_base,
    input  logic [5:0]   burst_len,
    input  logic         bvalid,
    input  logic [7:0]   bdata,
    output logic         bready,
    output logic         busy,
    output logic         done,
    output logic [255:0] regfile
);
    typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

    state_t     state_q, state_d;
    logic [4:0] ptr_q, ptr_d;
    logic [5:0] cnt_q, cnt_d;
    logic [7:0] regs_q [32];
    logic [7:0] regs_d [32];
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;

    // Next-state, burst bookkeeping and selection of the single write port
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        wr_en   = 1'b0;
        wr_addr = wsel;
        wr_data = wdata;
        case (state_q)
            IDLE: begin
                wr_en = we;
                if (burst_start) begin
                    ptr_d   = burst_base;
                    cnt_d   = burst_len;
                    state_d = (burst_len == 6'd0) ? DONE : BURST;
                end
            end
            BURST: begin
                if (bvalid) begin
                    wr_en   = 1'b1;
                    wr_addr = ptr_q;
                    wr_data = bdata;
                    ptr_d   = ptr_q + 5'd1;
                    cnt_d   = cnt_q - 6'd1;
                    state_d = (cnt_q == 6'd1) ? DONE : BURST;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // At most one register changes per cycle; everything else holds
    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[wr_addr] = wr_data;
    end

    // State, pointer, counter and register storage with reset priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 5'd0;
            cnt_q   <= 6'd0;
            regs_q  <= '{default: 8'h00};
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            regs_q  <= regs_d;
        end
    end

    assign bready = (state_q == BURST);
    assign busy   = bready;
    assign done   = (state_q == DONE);

    for (genvar i = 0; i < 32; i++) begin : g_flat
        assign regfile[8*i +: 8] = regs_q[i];
    end
endmodule

// File: tb/tb_regfile_writer.sv
// tb_regfile_writer: directed scenarios with a done-triggered regfile scoreboard
module tb_regfile_writer;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         we = 1'b0;
    logic [4:0]   wsel = '0;
    logic [7:0]   wdata = '0;
    logic         burst_start = 1'b0;
    logic [4:0]   burst_base = '0;
    logic [5:0]   burst_len = '0;
    logic         bvalid = 1'b0;
    logic [7:0]   bdata = '0;
    logic         bready, busy, done;
    logic [255:0] regfile;

    int n_vec = 0;
    int n_err = 0;
    logic [7:0]   m [32];
    logic [255:0] exp_q [$];

    regfile_writer dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .wdata(wdata),
        .burst_start(burst_start), .burst_base(burst_base), .burst_len(burst_len),
        .bvalid(bvalid), .bdata(bdata), .bready(bready), .busy(busy),
        .done(done), .regfile(regfile)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] flat();
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = m[i];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every done pulse must match the next queued expected regfile
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 256'd1, 256'd0);
            end else begin
                chk("done_regfile", regfile, exp_q.pop_front());
            end
        end
    end

    initial begin
        int bc;
        logic [7:0] d3 [4];
        for (int i = 0; i < 32; i++) m[i] = 8'h00;

        // Reset
        step();
        step();
        chk("reset_regfile", regfile, 256'd0);
        chk("reset_flags", {253'd0, bready, busy, done}, 256'd0);
        rst_n = 1'b1;

        // Single write to reg 5
        we = 1'b1; wsel = 5'd5; wdata = 8'hA5;
        step();
        we = 1'b0;
        m[5] = 8'hA5;
        chk("single_write_r5", regfile, flat());

        // Burst base 30, len 4, bvalid held high, wraps 31 -> 0
        burst_start = 1'b1; burst_base = 5'd30; burst_len = 6'd4;
        m[30] = 8'h11; m[31] = 8'h22; m[0] = 8'h33; m[1] = 8'h44;
        exp_q.push_back(flat());
        step();
        burst_start = 1'b0;
        d3 = '{8'h11, 8'h22, 8'h33, 8'h44};
        bc = 0;
        bvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bdata = d3[i];
            if (busy) bc++;
            step();
        end
        bvalid = 1'b0;
        chk("b4_busy_cycles", 256'(bc), 256'd4);
        chk("b4_done_after_last", {254'd0, done, busy}, 256'd2);
        step();
        chk("b4_done_one_cycle", {254'd0, done, busy}, 256'd0);
        chk("b4_regfile", regfile, flat());

        // Burst base 12, len 3, two stall cycles between beats 1 and 2
        burst_start = 1'b1; burst_base = 5'd12; burst_len = 6'd3;
        m[12] = 8'h5A; m[13] = 8'h6B; m[14] = 8'h7C;
        exp_q.push_back(flat());
        step();
        burst_start = 1'b0;
        bvalid = 1'b1; bdata = 8'h5A;
        step();
        bvalid = 1'b0; bdata = 8'hEE;
        bc = 0;
        for (int i = 0; i < 2; i++) begin
            if (busy) bc++;
            step();
        end
        chk("stall_busy", 256'(bc), 256'd2);
        chk("stall_no_write", regfile[13*8 +: 8], 8'h00);
        bvalid = 1'b1; bdata = 8'h6B;
        step();
        bdata = 8'h7C;
        step();
        bvalid = 1'b0;
        chk("stall_done", {254'd0, done, busy}, 256'd2);
        step();
        chk("stall_regfile", regfile, flat());

        // we and burst_start ignored during BURST
        burst_start = 1'b1; burst_base = 5'd8; burst_len = 6'd2;
        m[8] = 8'h81; m[9] = 8'h82;
        exp_q.push_back(flat());
        step();
        we = 1'b1; wsel = 5'd10; wdata = 8'hFF;
        burst_start = 1'b1; burst_base = 5'd20; burst_len = 6'd5;
        step();
        we = 1'b0; burst_start = 1'b0;
        chk("we_in_burst_r10", regfile[10*8 +: 8], 8'h00);
        bvalid = 1'b1; bdata = 8'h81;
        step();
        bdata = 8'h82;
        step();
        bvalid = 1'b0;
        step();
        step();
        chk("start_in_burst_ignored", {254'd0, busy, done}, 256'd0);
        chk("ignore_regfile", regfile, flat());

        // Single write and burst start in the same cycle; burst overwrites
        we = 1'b1; wsel = 5'd3; wdata = 8'h33;
        burst_start = 1'b1; burst_base = 5'd2; burst_len = 6'd2;
        m[2] = 8'h44; m[3] = 8'h55;
        exp_q.push_back(flat());
        step();
        we = 1'b0; burst_start = 1'b0;
        chk("same_cycle_write_r3", regfile[3*8 +: 8], 8'h33);
        chk("same_cycle_busy", {255'd0, busy}, 256'd1);
        bvalid = 1'b1; bdata = 8'h44;
        step();
        bdata = 8'h55;
        step();
        bvalid = 1'b0;
        step();
        chk("overwrite_regfile", regfile, flat());

        // Zero-length burst goes straight to DONE
        burst_start = 1'b1; burst_base = 5'd7; burst_len = 6'd0;
        exp_q.push_back(flat());
        step();
        burst_start = 1'b0;
        chk("len0_done", {254'd0, done, bready}, 256'd2);
        step();
        chk("len0_after", {254'd0, done, bready}, 256'd0);
        chk("len0_regfile", regfile, flat());

        // Reset in the middle of a 5-beat burst
        burst_start = 1'b1; burst_base = 5'd0; burst_len = 6'd5;
        step();
        burst_start = 1'b0;
        bvalid = 1'b1; bdata = 8'hA1;
        step();
        bdata = 8'hA2;
        step();
        bdata = 8'hA3;
        we = 1'b1; wsel = 5'd4; wdata = 8'h99;
        rst_n = 1'b0;
        step();
        bvalid = 1'b0; we = 1'b0;
        for (int i = 0; i < 32; i++) m[i] = 8'h00;
        chk("midrst_regfile", regfile, 256'd0);
        chk("midrst_flags", {253'd0, bready, busy, done}, 256'd0);
        rst_n = 1'b1;
        step();
        chk("midrst_no_done", {254'd0, done, busy}, 256'd0);
        we = 1'b1; wsel = 5'd31; wdata = 8'h3C;
        step();
        we = 1'b0;
        m[31] = 8'h3C;
        chk("post_rst_write", regfile, flat());
        step();
        chk("queue_drained", 256'(exp_q.size()), 256'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
